// File: rtl/csa_resolver.sv
// -----------------------------------------------------------------------------
// csa_resolver
//
// Carry-propagate back end for the carry-save adder array. Resolves a redundant
// (sum vector, carry vector) pair into one binary value, s_in + 2*c_in, using a
// chunked multi-cycle ripple: one CHUNK-bit slice per clock, LSB slice first.
// This keeps the full-width carry chain off the critical path.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   s_in       in   W    sum vector, bit i weight 2^i
//   c_in       in   W    carry vector, bit i weight 2^(i+1)
//   in_valid   in   1    s_in/c_in valid
//   in_ready   out  1    resolver can accept an operand pair (IDLE)
//   out_sum    out  W+2  resolved value, defined while out_valid=1
//   out_valid  out  1    out_sum valid (DONE)
//   out_ready  in   1    consumer accepts out_sum
//   busy       out  1    high in ADD or DONE
// -----------------------------------------------------------------------------
module csa_resolver #(
    parameter int W     = 15,
    parameter int CHUNK = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_in,
    input  logic [W-1:0] c_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W+1:0] out_sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int RW = W + 2;
    localparam int N  = (RW + CHUNK - 1) / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   a_q, a_d;
    logic [RW-1:0]   b_q, b_d;
    logic [RW-1:0]   sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [KW-1:0]   k_q, k_d;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice_sum;

    // Slice extraction: pick bits [k*CHUNK +: CHUNK] of A and B. Bits that
    // would lie above RW-1 in a partial last slice stay zero, so the padded
    // slice adds correctly and its carry-out is always 0.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < RW; i++) begin
            if ((i / CHUNK) == int'(k_q)) begin
                a_sl[i % CHUNK] = a_q[i];
                b_sl[i % CHUNK] = b_q[i];
            end
        end
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        k_d     = k_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {2'b00, s_in};
                    b_d     = {1'b0, c_in, 1'b0};
                    carry_d = 1'b0;
                    k_d     = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < RW; i++) begin
                    if ((i / CHUNK) == int'(k_q)) begin
                        sum_d[i] = slice_sum[i % CHUNK];
                    end
                end
                carry_d = slice_sum[CHUNK];
                k_d     = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
        end
    end

    // Operand registers; only meaningful after an accept, so no reset
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Carry-propagate back end for the 15-bit carry-save adder array. Takes a redundant (sum vector, carry vector) pair as produced by a CSA stage and resolves it to a single binary result.
- Uses a chunked, multi-cycle ripple: one CHUNK-bit slice per clock, LSB slice first. This keeps the long carry chain off the critical path.
- Sits between the CSA tree output and any consumer that needs a plain binary value.
- Uses a valid/ready handshake on both sides.

Parameters:
- W, 15, width of each redundant input vector (matches the CSA width).
- CHUNK, 5, bits resolved per clock; legal range 1..W+2.
- Derived, not overridable: RW = W+2 = 17 is the result width. N = ceil(RW/CHUNK) = 4 is the number of slice cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_in  in  W  sum vector from the CSA; bit i has weight 2^i.
- c_in  in  W  carry vector from the CSA; bit i has weight 2^(i+1).
- in_valid  in  1  s_in/c_in valid.
- in_ready  out  1  resolver can accept an operand pair.
- out_sum  out  RW  resolved binary value, s_in + 2*c_in.
- out_valid  out  1  out_sum valid.
- out_ready  in  1  consumer accepts out_sum.
- busy  out  1  high in ADD or DONE.

Behaviour:
- Reset (rst=1 at an edge, from any state): state=IDLE; out_sum=0; out_valid=0; busy=0; carry register=0; slice counter=0. After release, in_ready=1 on the first cycle.
- Operand formation at accept: A={2'b00,s_in}, B={1'b0,c_in,1'b0}, both RW bits, latched into internal registers.
- Arithmetic: exact sum A+B, no overflow possible. Maximum value is 3*(2^W-1) = 98301, which fits in 17 bits.
- State IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On an edge with in_valid=1: latch A/B, clear the carry register, set slice counter k=0, go to ADD.
- State ADD:
  - in_ready=0, busy=1.
  - Each cycle computes slice k: bits [k*CHUNK +: CHUNK] of A+B plus the carry register.
  - The result is written into the matching out_sum bits. The slice carry-out goes into the carry register; then k increments.
  - Last slice may be partial (bits above RW-1 ignored). Its carry-out is discarded, since it is always 0.
  - After slice N-1 completes: go to DONE and set out_valid=1.
- Latency: with accept at edge E0, out_valid=1 is visible after edge E0+N (4 cycles at defaults).
- State DONE:
  - out_valid=1, in_ready=0, busy=1. out_sum holds stable while out_ready=0 (no change for any number of cycles).
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - No same-cycle re-accept. Max throughput is one result per N+2 cycles.
- out_sum upper slices still show previous-result bits until overwritten during ADD. Only the value visible while out_valid=1 is defined.
- in_valid while in_ready=0 is ignored; s_in/c_in may change freely then.
- out_ready while out_valid=0 has no effect.
- rst asserted in ADD or DONE aborts: the partial or pending result is discarded and outputs take their reset values.
- CHUNK=RW gives N=1, a single-cycle resolve with the same handshake.

Test Plan:
- Basic: rst 2 cycles, then s_in=0x0001, c_in=0x0000, in_valid=1 one cycle, out_ready=1 -> out_valid exactly 4 cycles after accept edge, out_sum=0x00001, then back to IDLE with in_ready=1.
- Max carry chain: s_in=0x7FFF, c_in=0x7FFF -> out_sum=0x17FFD (98301); carry ripples across all 4 slices.
- Alternating pattern: s_in=0x5555, c_in=0x2AAA -> out_sum=0x0AAA9 (43689). Then s_in=0x0000, c_in=0x4000 -> out_sum=0x08000.
- Backpressure: after out_valid rises, hold out_ready=0 for 3 cycles -> out_sum/out_valid stable, in_ready=0, a pulsed in_valid is ignored; out_ready=1 -> out_valid falls next edge, in_ready=1.
- Reset mid-operation: accept s_in=0x7FFF, c_in=0x7FFF, assert rst at slice k=2 -> next cycle out_valid=0, out_sum=0, busy=0, in_ready=1. A following s_in=0x0003, c_in=0x0001 -> out_sum=0x00005.
- Back-to-back random: 1000 random pairs with in_valid held high and out_ready randomised -> every out_sum equals s_in+2*c_in; no pair lost or duplicated; accept spacing at least N+2 cycles.
